dmem_store_buffer_responder: RTL

Responder side of the memory-stage data-memory interface. It accepts at most one load or store per cycle from the dual-issue memory stage and formats load data combinationally for same-cycle writeback selection. Stores are posted into an in-order store buffer that drains into a single-port word array. The block raises `resp_busy` so the pipeline can stall the issuing lane when a request cannot complete this cycle.

---
 rtl/dmem_store_buffer_responder_if.sv | 32 +++
 rtl/dmem_store_buffer_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer_responder_if.sv
// Request/response bundle between the dual-issue memory stage and the data-memory responder.
// The master side drives req_*; the slave side returns resp_* and the store-buffer occupancy.
interface dmem_store_buffer_responder_if #(
    parameter int unsigned SB_DEPTH = 4
);
    localparam int unsigned CW = $clog2(SB_DEPTH + 1);

    logic          req_valid;
    logic          req_write;
    logic [1:0]    req_width;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [31:0]   req_pc;
    logic          req_is_inst1;
    logic [31:0]   resp_rdata;
    logic          resp_busy;
    logic          resp_misaligned;
    logic [CW-1:0] sb_count;

    modport master (
        output req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata, req_pc,
               req_is_inst1,
        input  resp_rdata, resp_busy, resp_misaligned, sb_count
    );

    modport slave (
        input  req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata, req_pc,
               req_is_inst1,
        output resp_rdata, resp_busy, resp_misaligned, sb_count
    );
endinterface

// File: rtl/dmem_store_buffer_responder.sv
// Data-memory responder: same-cycle formatted loads, stores posted to an in-order FIFO that
// drains into a single-port word array. Define DMEM_STORE_TRACE_EN for a per-drain trace.
module dmem_store_buffer_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned SB_DEPTH  = 4
) (
    input logic                          clk,
    input logic                          rst,
    dmem_store_buffer_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(SB_DEPTH);
    localparam int unsigned CW = $clog2(SB_DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [3:0]    mask;
        logic [31:0]   data;
`ifdef DMEM_STORE_TRACE_EN
        logic [31:0]   pc;
        logic          is_inst1;
`endif
    } entry_t;

    logic [31:0]         mem [MEM_WORDS];
    entry_t              sb_q [SB_DEPTH];
    logic [SB_DEPTH-1:0] valid_q;
    logic [PW-1:0]       head_q, tail_q;
    logic [CW-1:0]       count_q;

    logic [AW-1:0] req_idx;
    logic [1:0]    lane;
    logic          misaligned, active, full, hazard, busy, enq, drain;
    logic [3:0]    st_mask;
    logic [31:0]   st_data, rd_word, rdata;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    entry_t        head_entry, new_entry;
    logic          unused_bits;

    assign req_idx = bus.req_addr[2 +: AW];
    assign lane    = bus.req_addr[1:0];

    always_comb begin
        case (bus.req_width)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(SB_DEPTH); i++) begin
            if (valid_q[i] && (sb_q[i].idx == req_idx)) hazard = 1'b1;
        end
    end

    assign active = bus.req_valid && !misaligned;
    assign full   = (count_q == CW'(SB_DEPTH));
    assign busy   = active && (bus.req_write ? full : hazard);
    assign enq    = active && bus.req_write && !full;
    // Single array port: drain only when no completing request owns it; reset discards the head.
    assign drain  = (count_q != '0) && (!bus.req_valid || busy) && !rst;

    // Data is replicated across lanes so the mask alone selects the target bytes.
    always_comb begin
        case (bus.req_width)
            2'b00: begin
                st_mask = 4'b0001 << lane;
                st_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << lane;
                st_data = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = bus.req_wdata;
            end
        endcase
    end

    assign rd_word = mem[req_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        rdata = 32'h0;
        if (active && !bus.req_write && !hazard) begin
            case (bus.req_width)
                2'b00:   rdata = {{24{!bus.req_unsigned && rd_byte[7]}}, rd_byte};
                2'b01:   rdata = {{16{!bus.req_unsigned && rd_half[15]}}, rd_half};
                default: rdata = rd_word;
            endcase
        end
    end

    always_comb begin
        new_entry      = '0;
        new_entry.idx  = req_idx;
        new_entry.mask = st_mask;
        new_entry.data = st_data;
`ifdef DMEM_STORE_TRACE_EN
        new_entry.pc       = bus.req_pc;
        new_entry.is_inst1 = bus.req_is_inst1;
`endif
    end

    assign head_entry = sb_q[head_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (enq) begin
                sb_q[tail_q]    <= new_entry;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            count_q <= count_q + CW'(enq) - CW'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (drain) begin
            for (int b = 0; b < 4; b++) begin
                if (head_entry.mask[b]) mem[head_entry.idx][b*8 +: 8] <= head_entry.data[b*8 +: 8];
            end
        end
    end

`ifdef DMEM_STORE_TRACE_EN
    always_ff @(posedge clk) begin
        if (drain) begin
            $display("sb drain pc=%08h widx=%0h mask=%b data=%08h lane=%0d", head_entry.pc,
                     head_entry.idx, head_entry.mask, head_entry.data, head_entry.is_inst1);
        end
    end
`endif

    assign unused_bits = ^{bus.req_addr, bus.req_pc, bus.req_is_inst1};

    assign bus.resp_rdata      = rdata;
    assign bus.resp_busy       = busy;
    assign bus.resp_misaligned = active ? 1'b0 : bus.req_valid;
    assign bus.sb_count        = count_q;
endmodule
